// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: datapath width, writeback select and load funct3 encodings.
package riscv_pkg;

   localparam int XLEN = 64;

   // Writeback result select
   localparam logic [1:0] WB_ALU  = 2'b00;
   localparam logic [1:0] WB_LOAD = 2'b01;
   localparam logic [1:0] WB_PC4  = 2'b10;
   localparam logic [1:0] WB_IMM  = 2'b11;

   // Load size / signedness (funct3)
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/writeback_stage_load_extend.sv
// load_extend: combinational sign/zero extension of right-aligned load data.
// The reserved funct3 code 111 behaves like LD (full 64 bits pass through).
module load_extend
   import riscv_pkg::*;
(
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] raw_data,
   output logic [XLEN-1:0] ext_data
);

   // Pick the loaded field and extend it according to funct3
   always_comb begin
      ext_data = raw_data;
      case (funct3)
         F3_LB:   ext_data = {{56{raw_data[7]}},  raw_data[7:0]};
         F3_LH:   ext_data = {{48{raw_data[15]}}, raw_data[15:0]};
         F3_LW:   ext_data = {{32{raw_data[31]}}, raw_data[31:0]};
         F3_LBU:  ext_data = {56'd0, raw_data[7:0]};
         F3_LHU:  ext_data = {48'd0, raw_data[15:0]};
         F3_LWU:  ext_data = {32'd0, raw_data[31:0]};
         default: ext_data = raw_data;
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage. Registers the selected result and drives
// the register file write port, with stall/flush control and x0 write suppression.
// Optional retired-instruction counter enabled by defining WB_INSTRET_EN.
//
// Handshake: an instruction transfers on a rising edge when in_valid && in_ready,
// unless wb_flush is high on that edge. in_ready is !wb_stall and depends on
// nothing else; in_valid may be asserted regardless of in_ready.
module writeback_stage
   import riscv_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_reg_write,
   input  logic [4:0]      in_rd,
   input  logic [1:0]      in_wb_sel,
   input  logic [2:0]      in_load_funct3,
   input  logic [XLEN-1:0] in_alu_result,
   input  logic [XLEN-1:0] in_load_data,
   input  logic [XLEN-1:0] in_pc_plus4,
   input  logic [XLEN-1:0] in_imm,
   input  logic            wb_stall,
   input  logic            wb_flush,
   output logic            rf_write_en,
   output logic [4:0]      rf_write_register,
   output logic [XLEN-1:0] rf_write_data
`ifdef WB_INSTRET_EN
   ,
   output logic [63:0]     instret
`endif
);

   logic [XLEN-1:0] load_ext;
   logic [XLEN-1:0] sel_data;
   logic            capture;
   logic            wb_valid;
   logic            wb_reg_write;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;

   load_extend u_load_extend (
      .funct3   (in_load_funct3),
      .raw_data (in_load_data),
      .ext_data (load_ext)
   );

   assign in_ready = !wb_stall;
   assign capture  = in_valid && in_ready && !wb_flush;

   // Select the value that will retire for the incoming instruction
   always_comb begin
      sel_data = in_alu_result;
      case (in_wb_sel)
         WB_ALU:  sel_data = in_alu_result;
         WB_LOAD: sel_data = load_ext;
         WB_PC4:  sel_data = in_pc_plus4;
         WB_IMM:  sel_data = in_imm;
         default: sel_data = in_alu_result;
      endcase
   end

   // Stage valid bit: flush wins, stall holds, otherwise follow capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid <= 1'b0;
      end else if (wb_flush) begin
         wb_valid <= 1'b0;
      end else if (!wb_stall) begin
         wb_valid <= capture;
      end
   end

   // Stage payload: loaded only on capture so it stays stable while held
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_reg_write <= 1'b0;
         wb_rd        <= 5'd0;
         wb_data      <= '0;
      end else if (capture) begin
         wb_reg_write <= in_reg_write;
         wb_rd        <= in_rd;
         wb_data      <= sel_data;
      end
   end

   // The stall term is the only combinational path into the write enable
   assign rf_write_en       = wb_valid && wb_reg_write && (wb_rd != 5'd0) && !wb_stall;
   assign rf_write_register = wb_rd;
   assign rf_write_data     = wb_data;

`ifdef WB_INSTRET_EN
   // Count every instruction leaving the stage, including ones that write nothing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instret <= 64'd0;
      end else if (wb_valid && !wb_stall && !wb_flush) begin
         instret <= instret + 64'd1;
      end
   end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed testbench for writeback_stage. Define WB_INSTRET_EN to also cover instret.
module tb_writeback_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_reg_write;
   logic [4:0]  in_rd;
   logic [1:0]  in_wb_sel;
   logic [2:0]  in_load_funct3;
   logic [63:0] in_alu_result;
   logic [63:0] in_load_data;
   logic [63:0] in_pc_plus4;
   logic [63:0] in_imm;
   logic        wb_stall;
   logic        wb_flush;
   logic        rf_write_en;
   logic [4:0]  rf_write_register;
   logic [63:0] rf_write_data;
`ifdef WB_INSTRET_EN
   logic [63:0] instret;
   logic [63:0] instret_base;
`endif

   int n_vectors;
   int n_miscompares;

   writeback_stage dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_reg_write      (in_reg_write),
      .in_rd             (in_rd),
      .in_wb_sel         (in_wb_sel),
      .in_load_funct3    (in_load_funct3),
      .in_alu_result     (in_alu_result),
      .in_load_data      (in_load_data),
      .in_pc_plus4       (in_pc_plus4),
      .in_imm            (in_imm),
      .wb_stall          (wb_stall),
      .wb_flush          (wb_flush),
      .rf_write_en       (rf_write_en),
      .rf_write_register (rf_write_register),
      .rf_write_data     (rf_write_data)
`ifdef WB_INSTRET_EN
      ,
      .instret           (instret)
`endif
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vectors++;
      if (act !== exp) begin
         n_miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_insn(input logic v, input logic rw, input logic [4:0] rd,
                             input logic [1:0] sel, input logic [2:0] f3,
                             input logic [63:0] alu, input logic [63:0] ld,
                             input logic [63:0] pc4, input logic [63:0] imm);
      in_valid       = v;
      in_reg_write   = rw;
      in_rd          = rd;
      in_wb_sel      = sel;
      in_load_funct3 = f3;
      in_alu_result  = alu;
      in_load_data   = ld;
      in_pc_plus4    = pc4;
      in_imm         = imm;
   endtask

   task automatic idle();
      drive_insn(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 64'h0, 64'h0, 64'h0, 64'h0);
   endtask

   // Send one load, then check the write it produces in the next cycle
   task automatic load_case(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                            input logic [63:0] ld, input logic [63:0] exp);
      drive_insn(1'b1, 1'b1, rd, 2'b01, f3, 64'hDEAD, ld, 64'h4, 64'h8);
      tick();
      idle();
      #1;
      check({tag, "_en"}, 64'(rf_write_en), 64'd1);
      check({tag, "_rd"}, 64'(rf_write_register), 64'(rd));
      check({tag, "_data"}, rf_write_data, exp);
   endtask

   initial begin
      n_vectors     = 0;
      n_miscompares = 0;
      rst_n    = 1'b0;
      wb_stall = 1'b0;
      wb_flush = 1'b0;
      idle();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_en", 64'(rf_write_en), 64'd0);
      check("reset_rd", 64'(rf_write_register), 64'd0);
      check("reset_data", rf_write_data, 64'd0);
      check("reset_ready", 64'(in_ready), 64'd1);
`ifdef WB_INSTRET_EN
      check("reset_instret", instret, 64'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("post_reset_en", 64'(rf_write_en), 64'd0);

      // Load extension and result select
      load_case("lb",  3'b000, 5'd5,  64'h80, 64'hFFFF_FFFF_FFFF_FF80);
      load_case("lbu", 3'b100, 5'd5,  64'h80, 64'h80);
      load_case("lh",  3'b001, 5'd6,  64'h1234_8001, 64'hFFFF_FFFF_FFFF_8001);
      load_case("lhu", 3'b101, 5'd6,  64'h1234_8001, 64'h8001);
      load_case("lw",  3'b010, 5'd8,  64'hAB_8000_0000, 64'hFFFF_FFFF_8000_0000);
      load_case("lwu", 3'b110, 5'd8,  64'hAB_8000_0000, 64'h8000_0000);
      load_case("ld",  3'b011, 5'd9,  64'hF123_4567_89AB_CDEF, 64'hF123_4567_89AB_CDEF);
      load_case("rsv", 3'b111, 5'd31, 64'h8765_4321_0FED_CBA9, 64'h8765_4321_0FED_CBA9);

      drive_insn(1'b1, 1'b1, 5'd12, 2'b11, 3'b000, 64'h11, 64'h22, 64'h33, 64'h44);
      tick();
      idle();
      #1;
      check("imm_data", rf_write_data, 64'h44);
      drive_insn(1'b1, 1'b1, 5'd13, 2'b10, 3'b000, 64'h11, 64'h22, 64'h33, 64'h44);
      tick();
      idle();
      #1;
      check("pc4_data", rf_write_data, 64'h33);
      drive_insn(1'b1, 1'b0, 5'd14, 2'b00, 3'b000, 64'h11, 64'h22, 64'h33, 64'h44);
      tick();
      idle();
      #1;
      check("noregw_en", 64'(rf_write_en), 64'd0);
      check("alu_data", rf_write_data, 64'h11);
      tick();

      // x0 suppression
`ifdef WB_INSTRET_EN
      instret_base = instret;
`endif
      drive_insn(1'b1, 1'b1, 5'd0, 2'b00, 3'b000, 64'h1234, 64'h0, 64'h0, 64'h0);
      tick();
      idle();
      #1;
      check("x0_en", 64'(rf_write_en), 64'd0);
      check("x0_data", rf_write_data, 64'h1234);
      tick();
`ifdef WB_INSTRET_EN
      check("x0_instret", instret - instret_base, 64'd1);
`endif

      // Stall hold with a competing instruction offered during the stall
      drive_insn(1'b1, 1'b1, 5'd7, 2'b00, 3'b000, 64'hAA, 64'h0, 64'h0, 64'h0);
      tick();
      wb_stall = 1'b1;
      drive_insn(1'b1, 1'b1, 5'd9, 2'b00, 3'b000, 64'hBB, 64'h0, 64'h0, 64'h0);
`ifdef WB_INSTRET_EN
      instret_base = instret;
`endif
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_en", 64'(rf_write_en), 64'd0);
         check("stall_ready", 64'(in_ready), 64'd0);
         tick();
      end
      wb_stall = 1'b0;
      idle();
      #1;
`ifdef WB_INSTRET_EN
      check("stall_instret_hold", instret, instret_base);
`endif
      check("release_en", 64'(rf_write_en), 64'd1);
      check("release_rd", 64'(rf_write_register), 64'd7);
      check("release_data", rf_write_data, 64'hAA);
      tick();
      check("release_once", 64'(rf_write_en), 64'd0);

      // Flush beats stall and discards the held write
      drive_insn(1'b1, 1'b1, 5'd10, 2'b00, 3'b000, 64'h55, 64'h0, 64'h0, 64'h0);
      tick();
      idle();
      wb_stall = 1'b1;
      wb_flush = 1'b1;
      #1;
      check("flush_stall_en", 64'(rf_write_en), 64'd0);
      tick();
      wb_flush = 1'b0;
      tick();
      wb_stall = 1'b0;
      #1;
      check("flush_no_write", 64'(rf_write_en), 64'd0);
      tick();
      check("flush_no_write2", 64'(rf_write_en), 64'd0);

      // Simultaneous valid and flush captures nothing
      drive_insn(1'b1, 1'b1, 5'd11, 2'b00, 3'b000, 64'h66, 64'h0, 64'h0, 64'h0);
      wb_flush = 1'b1;
      tick();
      wb_flush = 1'b0;
      idle();
      #1;
      check("valid_flush_en", 64'(rf_write_en), 64'd0);
      tick();

      // Asynchronous reset with a write pending
      drive_insn(1'b1, 1'b1, 5'd3, 2'b00, 3'b000, 64'h77, 64'h0, 64'h0, 64'h0);
      tick();
      idle();
      #1;
      check("pre_reset_en", 64'(rf_write_en), 64'd1);
      rst_n = 1'b0;
      #1;
      check("async_reset_en", 64'(rf_write_en), 64'd0);
      check("async_reset_rd", 64'(rf_write_register), 64'd0);
      check("async_reset_data", rf_write_data, 64'd0);
`ifdef WB_INSTRET_EN
      check("async_reset_instret", instret, 64'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("after_async_reset_en", 64'(rf_write_en), 64'd0);

      // Back-to-back: one write per cycle, in order
      for (int i = 1; i <= 4; i++) begin
         drive_insn(1'b1, 1'b1, 5'(i), 2'b10, 3'b000, 64'h0, 64'h0, 64'(4 * i), 64'h0);
         tick();
         check("b2b_en", 64'(rf_write_en), 64'd1);
         check("b2b_rd", 64'(rf_write_register), 64'(i));
         check("b2b_data", rf_write_data, 64'(4 * i));
      end
      idle();
      tick();
      check("b2b_done_en", 64'(rf_write_en), 64'd0);
`ifdef WB_INSTRET_EN
      check("b2b_instret", instret, 64'd4);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final pipeline stage of the RISC-V CPU: registers the MEM/WB result, selects the value to retire (ALU, sized load, PC+4, immediate), and drives the write port of the register file (`registers`). It provides one cycle of pipeline registering and honours stall and flush controls from the hazard unit. It suppresses writes to x0 and optionally counts retired instructions.

## Interface
- `XLEN`, 64, datapath width; must equal the register file width; only 64 is supported.
- `clk`  in  1  rising-edge clock shared with the register file.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  MEM stage presents a retiring instruction.
- `in_ready`  out  1  stage accepts on this edge; equals `!wb_stall`.
- `in_reg_write`  in  1  instruction writes rd.
- `in_rd`  in  5  destination register index.
- `in_wb_sel`  in  2  00 ALU, 01 load, 10 PC+4, 11 immediate.
- `in_load_funct3`  in  3  load size and sign: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
- `in_alu_result`, `in_load_data`, `in_pc_plus4`, `in_imm`  in  XLEN each  candidate results; `in_load_data` is already right-aligned.
- `wb_stall`  in  1  hold stage contents and defer the write.
- `wb_flush`  in  1  discard the incoming instruction and the held instruction.
- `rf_write_en`  out  1  connects to the register file `enable`.
- `rf_write_register`  out  5  connects to `write_register`.
- `rf_write_data`  out  XLEN  connects to `reg_write_data`.
- `instret`  out  64  retired-instruction count; present only with `WB_INSTRET_EN`.

## Operation
- Result selection and load extension are combinational on the inputs. The selected value is captured into the stage register.
- Load extension:
  - LB, LH and LW sign-extend bits [7:0], [15:0] and [31:0].
  - LBU, LHU and LWU zero-extend the same fields.
  - LD passes all 64 bits.
  - Reserved code 111 is treated as LD.
- Capture occurs on an edge when `in_valid && in_ready && !wb_flush`. The edge sets `wb_valid` and loads rd, reg_write and the data.
- If no capture occurs and the stage is not stalled, `wb_valid` clears on the edge.
- `rf_write_en = wb_valid && wb_reg_write && (wb_rd != 0) && !wb_stall`. A write to x0 never reaches the register file.
- `rf_write_register` and `rf_write_data` always reflect the stage register, including when `rf_write_en` is low.
- Stall: the stage register holds and `in_ready` is 0. The write is deferred and issues exactly once, in the first cycle after `wb_stall` falls.
- Flush: `wb_valid` clears on the next edge. Flush has priority over capture and over stall; a held, deferred write is discarded.
- Reset values: `wb_valid` 0, `rf_write_en` 0, `rf_write_register` 0, `rf_write_data` 0, `instret` 0.
- Reset mid-operation drops any pending write. No write is issued during reset or in the first cycle after reset.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N drives `rf_write_en` during cycle N→N+1 and commits in the register file at edge N+1.
- Back-to-back acceptance is supported: throughput is 1 instruction per cycle when not stalled.
- `in_ready` is combinational from `wb_stall` only. There is no path from the data inputs to `in_ready`.
- All `rf_*` outputs are registered except the `!wb_stall` term in `rf_write_en`.
- Simultaneous `in_valid` and `wb_flush`: nothing is captured and `wb_valid` is 0 next cycle.

## Configuration
- `WB_INSTRET_EN` defined:
  - Adds the 64-bit `instret` output and counter.
  - The counter increments by 1 on every edge where `wb_valid && !wb_stall && !wb_flush`, including instructions with `in_reg_write=0` and rd=x0.
  - The counter wraps from 2^64-1 to 0.
- `WB_INSTRET_EN` undefined: no counter and no `instret` port. All other behaviour is identical.

## Structure
- Shared package `riscv_pkg` holds:
  - `XLEN` constant.
  - wb_sel encoding constants (`WB_ALU`, `WB_LOAD`, `WB_PC4`, `WB_IMM`).
  - Load funct3 constants (`F3_LB` … `F3_LWU`).
- One sub-module, `load_extend`: purely combinational, mapping funct3 + raw data to a 64-bit result.
- The pipeline register, write gating and counter stay in `writeback_stage`.

## Test plan
- LB sign: `in_load_data=0x80`, funct3 000, `in_wb_sel=01`, rd=5 → next cycle `rf_write_en=1`, rd=5, data `0xFFFFFFFFFFFFFF80`. LBU with the same data → `0x80`.
- x0 suppression: `in_reg_write=1`, rd=0, ALU result `0x1234` → `rf_write_en` stays 0; `instret` increments by 1.
- Stall hold: accept rd=7 with ALU result `0xAA`, then `wb_stall=1` for 3 cycles → `rf_write_en=0` and `in_ready=0` throughout. Release the stall → exactly one cycle with `rf_write_en=1`, rd=7, data `0xAA`.
- Flush priority: `wb_stall=1` and `wb_flush=1` with an instruction held → the next cycle has `wb_valid=0`, and no write occurs after the stall releases.
- Back-to-back: 4 consecutive valid instructions writing rd=1..4 with PC+4 values 4, 8, 12, 16 → writes issue on 4 consecutive cycles in order; `instret` = 4.
- Async reset: assert `rst_n=0` mid-cycle while a write is pending → `rf_write_en=0` immediately, with all outputs at their reset values.
